// File: rtl/sensor_request_scheduler_pkg.sv
// sensor_request_scheduler_pkg: command/response codes and FSM states shared by the scheduler files.
package sensor_request_scheduler_pkg;
    localparam logic [7:0] CMD_01        = 8'h01;
    localparam logic [7:0] CMD_02        = 8'h02;
    localparam logic [7:0] CMD_TEMP      = 8'h03;
    localparam logic [7:0] CMD_HUM       = 8'h04;
    localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
    localparam logic [7:0] CMD_STOP_HUM  = 8'h06;
    localparam logic [7:0] CMD_AC        = 8'hAC;
    localparam logic [7:0] RSP_0D        = 8'h0D;
    localparam logic [7:0] RSP_0E        = 8'h0E;
    localparam logic [7:0] RSP_0A        = 8'h0A;
    localparam logic [7:0] RSP_0B        = 8'h0B;
    localparam logic [7:0] RSP_TIMEOUT   = 8'h1F;
    localparam logic [7:0] RSP_BAD_ADDR  = 8'hFA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP
    } sched_state_t;
endpackage

// File: rtl/sensor_request_scheduler_rr_pending_picker.sv
// rr_pending_picker: first set bit of pending at or after rr_ptr, wrapping around N slots.
module rr_pending_picker #(
    parameter int N = 8
) (
    input  logic [N-1:0]         pending,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);
    int s;
    logic [IW-1:0] j;
    // Scan from the farthest slot back toward rr_ptr so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx = '0;
        s = 0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(rr_ptr) + k;
            s = s >= N ? s - N : s;
            j = IW'(s);
            if (pending[j]) begin
                found = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/sensor_request_scheduler.sv
// sensor_request_scheduler: routes host requests to sensor units, collects/synthesises responses,
// and re-triggers continuous-sensing slots round-robin every loop period.
module sensor_request_scheduler #(
    parameter int NUM_SENSORS     = 8,
    parameter int LOOP_PERIOD_CYC = 100_000_000,
    parameter int TIMEOUT_CYC     = 5_000_000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_command,
    input  logic [7:0]               req_address,
    output logic [NUM_SENSORS-1:0]   sens_enable,
    output logic [7:0]               sens_command,
    input  logic [NUM_SENSORS-1:0]   sens_done,
    input  logic [8*NUM_SENSORS-1:0] sens_resp_command,
    input  logic [8*NUM_SENSORS-1:0] sens_resp_value,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_command,
    output logic [7:0]               rsp_value,
    output logic [7:0]               rsp_address,
    output logic                     busy
);
    import sensor_request_scheduler_pkg::*;

    localparam int IW = $clog2(NUM_SENSORS);
    localparam int PW = $clog2(LOOP_PERIOD_CYC);
    localparam int TW = $clog2(TIMEOUT_CYC);

    sched_state_t state, next_state;
    logic [IW-1:0] idx, rr_ptr, pick_idx, rr_next;
    logic [7:0] cmd;
    logic table_upd_ok;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [NUM_SENSORS-1:0] loop_active, loop_kind, loop_pending;
    logic [NUM_SENSORS-1:0] active_next, kind_next, pending_next;
    logic pick_found, accept, bad_addr, service, slot_done, timeout_hit, wrap, table_upd;

    rr_pending_picker #(.N(NUM_SENSORS)) u_picker (
        .pending(loop_pending),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign req_ready    = reset_n && state == S_IDLE;
    assign accept       = req_valid && req_ready;
    assign bad_addr     = req_address >= 8'(NUM_SENSORS);
    assign service      = state == S_IDLE && !req_valid && pick_found;
    assign slot_done    = sens_done[idx];
    assign timeout_hit  = state == S_WAIT && !slot_done && timeout_cnt == TW'(TIMEOUT_CYC - 1);
    assign wrap         = period_cnt == PW'(LOOP_PERIOD_CYC - 1);
    assign table_upd    = state == S_RESP && rsp_ready && table_upd_ok;
    assign rr_next      = pick_idx == IW'(NUM_SENSORS - 1) ? '0 : pick_idx + 1'b1;
    assign sens_enable  = (state == S_ISSUE || state == S_WAIT) ? NUM_SENSORS'(1) << idx : '0;
    assign sens_command = cmd;
    assign rsp_valid    = state == S_RESP;
    assign busy         = state != S_IDLE;

    always_ff @(posedge clock) state <= !reset_n ? S_IDLE : next_state;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = accept ? (bad_addr ? S_RESP : S_ISSUE) : (service ? S_ISSUE : S_IDLE);
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  next_state = (slot_done || timeout_hit) ? S_RESP : S_WAIT;
            S_RESP:  next_state = rsp_ready ? S_GAP : S_RESP;
            default: next_state = S_IDLE;
        endcase
    end

    // Ordering gives the conflict rules: wrap re-arms a slot just serviced, deactivation beats wrap.
    always_comb begin
        active_next = loop_active;
        kind_next = loop_kind;
        pending_next = loop_pending;
        if (service) pending_next[pick_idx] = 1'b0;
        if (wrap) pending_next = pending_next | loop_active;
        if (table_upd && (cmd == CMD_TEMP || cmd == CMD_HUM)) begin
            active_next[idx] = 1'b1;
            kind_next[idx] = cmd == CMD_HUM;
        end
        if (table_upd && (cmd == CMD_STOP_TEMP || cmd == CMD_STOP_HUM)) begin
            active_next[idx] = 1'b0;
            pending_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idx <= '0;
            cmd <= '0;
            rr_ptr <= '0;
            table_upd_ok <= 1'b0;
            period_cnt <= '0;
            timeout_cnt <= '0;
            loop_active <= '0;
            loop_kind <= '0;
            loop_pending <= '0;
            rsp_command <= '0;
            rsp_value <= '0;
            rsp_address <= '0;
        end else begin
            period_cnt <= wrap ? '0 : period_cnt + 1'b1;
            loop_active <= active_next;
            loop_kind <= kind_next;
            loop_pending <= pending_next;
            if (accept) begin
                idx <= req_address[IW-1:0];
                cmd <= req_command;
                table_upd_ok <= !bad_addr;
                rsp_address <= req_address;
                if (bad_addr) begin
                    rsp_command <= RSP_BAD_ADDR;
                    rsp_value <= RSP_BAD_ADDR;
                end
            end else if (service) begin
                idx <= pick_idx;
                cmd <= loop_kind[pick_idx] ? CMD_HUM : CMD_TEMP;
                table_upd_ok <= 1'b0;
                rsp_address <= 8'(pick_idx);
                rr_ptr <= rr_next;
            end
            if (state == S_ISSUE) timeout_cnt <= '0;
            else if (state == S_WAIT) timeout_cnt <= timeout_cnt + 1'b1;
            if (state == S_WAIT && slot_done) begin
                rsp_command <= sens_resp_command[8*idx +: 8];
                rsp_value <= sens_resp_value[8*idx +: 8];
            end else if (timeout_hit) begin
                rsp_command <= RSP_TIMEOUT;
                rsp_value <= RSP_TIMEOUT;
                table_upd_ok <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sensor_request_scheduler.sv
// tb_sensor_request_scheduler: scenario tasks against sensor stubs and a loop-table reference model.
module tb_sensor_request_scheduler;
    localparam int N = 4;
    localparam int P = 1000;
    localparam int T = 100;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [7:0] req_command = '0;
    logic [7:0] req_address = '0;
    logic [N-1:0] sens_enable;
    logic [7:0] sens_command;
    logic [N-1:0] sens_done;
    logic [8*N-1:0] sens_resp_command, sens_resp_value;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [7:0] rsp_command, rsp_value, rsp_address;
    logic busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    logic [7:0] stub_cmd[N];
    logic [7:0] stub_val[N];
    int stub_delay[N];
    int en_cnt[N];
    logic [N-1:0] prev_en = '0;
    int iss_slot[$];
    logic [7:0] iss_cmd[$];
    bit m_active[N];
    bit m_hum[N];
    int m_rr;

    always #5 clock = ~clock;

    sensor_request_scheduler #(.NUM_SENSORS(N), .LOOP_PERIOD_CYC(P), .TIMEOUT_CYC(T)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command), .req_address(req_address),
        .sens_enable(sens_enable), .sens_command(sens_command), .sens_done(sens_done),
        .sens_resp_command(sens_resp_command), .sens_resp_value(sens_resp_value),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_command(rsp_command),
        .rsp_value(rsp_value), .rsp_address(rsp_address), .busy(busy)
    );

    // Sensor stubs: done rises stub_delay cycles into an enable; delay 0 never answers.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            sens_done[i] = stub_delay[i] != 0 && en_cnt[i] >= stub_delay[i];
            sens_resp_command[8*i +: 8] = stub_cmd[i];
            sens_resp_value[8*i +: 8] = stub_val[i];
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < N; i++) en_cnt[i] <= sens_enable[i] ? en_cnt[i] + 1 : 0;
        if (sens_enable != 0 && prev_en == 0)
            for (int i = 0; i < N; i++)
                if (sens_enable[i]) begin
                    iss_slot.push_back(i);
                    iss_cmd.push_back(sens_command);
                end
        prev_en <= sens_enable;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    always @(posedge clock) cyc <= reset_n ? cyc + 1 : 0;

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_active[i] = 1'b0;
            m_hum[i] = 1'b0;
        end
        m_rr = 0;
    endtask

    task automatic host_req(input logic [7:0] c, input logic [7:0] a);
        bit ok = 1'b0;
        @(negedge clock);
        req_valid = 1'b1;
        req_command = c;
        req_address = a;
        for (int k = 0; k < 3000; k++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL host_accept: req_ready=0 required 1 (cmd %h addr %0d)", c, a);
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [7:0] c, output logic [7:0] v, output logic [7:0] a);
        bit got = 1'b0;
        c = '0;
        v = '0;
        a = '0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (rsp_valid) begin
                got = 1'b1;
                c = rsp_command;
                v = rsp_value;
                a = rsp_address;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rsp_wait: rsp_valid=0 required 1 within bound");
        end
        @(posedge clock);
        #1;
    endtask

    // Expected service order for the given number of wraps: each wrap arms every active slot,
    // which are then taken in cyclic order starting from the round-robin pointer.
    task automatic model_rounds(input int rounds, output int es[$], output logic [7:0] ec[$]);
        int start;
        int s;
        es = {};
        ec = {};
        for (int r = 0; r < rounds; r++) begin
            start = m_rr;
            for (int k = 0; k < N; k++) begin
                s = (start + k) % N;
                if (m_active[s]) begin
                    es.push_back(s);
                    ec.push_back(m_hum[s] ? 8'h04 : 8'h03);
                    m_rr = (s + 1) % N;
                end
            end
        end
    endtask

    task automatic check_issues(input string name, input int base, input int es[$], input logic [7:0] ec[$]);
        for (int i = 0; i < es.size(); i++) begin
            total++;
            if (base + i >= iss_slot.size()) begin
                bad++;
                $display("FAIL %s[%0d]: no issue seen, required slot %0d cmd %h", name, i, es[i], ec[i]);
            end else if (iss_slot[base+i] !== es[i] || iss_cmd[base+i] !== ec[i]) begin
                bad++;
                $display("FAIL %s[%0d]: slot %0d cmd %h, required slot %0d cmd %h", name, i,
                         iss_slot[base+i], iss_cmd[base+i], es[i], ec[i]);
            end
        end
    endtask

    task automatic wait_issues(input int base, input int n, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (iss_slot.size() - base >= n) break;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({sens_enable, rsp_valid, req_ready, busy} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: en=%b rv=%b rr=%b busy=%b, required all 0", sens_enable, rsp_valid, req_ready, busy);
        end
        total++;
        if ({sens_command, rsp_command, rsp_value, rsp_address} !== '0) begin
            bad++;
            $display("FAIL reset_data: %h %h %h %h, required all 00", sens_command, rsp_command, rsp_value, rsp_address);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_route();
        int a;
        logic [7:0] c, rc, rv, ra;
        logic [N-1:0] exp_en;
        for (int it = 0; it < 5; it++) begin
            a = it == 0 ? 2 : int'($urandom_range(0, N - 1));
            stub_delay[a] = it == 0 ? 10 : int'($urandom_range(1, 30));
            stub_cmd[a] = it == 0 ? 8'h09 : 8'($urandom);
            stub_val[a] = it == 0 ? 8'h19 : 8'($urandom);
            c = it == 0 ? 8'h01 : 8'($urandom_range(1, 2));
            exp_en = '0;
            exp_en[a] = 1'b1;
            host_req(c, 8'(a));
            @(negedge clock);
            total++;
            if (sens_enable !== exp_en) begin
                bad++;
                $display("FAIL route_enable: %b, required %b", sens_enable, exp_en);
            end
            wait_rsp(rc, rv, ra);
            total++;
            if ({rc, rv, ra} !== {stub_cmd[a], stub_val[a], 8'(a)}) begin
                bad++;
                $display("FAIL route_rsp: %h/%h addr %0d, required %h/%h addr %0d", rc, rv, ra, stub_cmd[a], stub_val[a], a);
            end
        end
    endtask

    task automatic test_bad_addr();
        logic [7:0] a, c;
        for (int it = 0; it < 3; it++) begin
            a = it == 0 ? 8'd5 : 8'($urandom_range(N, 255));
            c = it == 0 ? 8'h03 : 8'($urandom_range(1, 6));
            host_req(c, a);
            @(negedge clock);
            total++;
            if (rsp_valid !== 1'b1 || rsp_command !== 8'hFA || rsp_value !== 8'hFA || rsp_address !== a || sens_enable !== '0) begin
                bad++;
                $display("FAIL bad_addr: rv=%b %h/%h addr %0d en=%b, required rv=1 fa/fa addr %0d en=0",
                         rsp_valid, rsp_command, rsp_value, rsp_address, sens_enable, a);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int base;
        bit got = 1'b0;
        stub_delay[1] = 0;
        host_req(8'h03, 8'd1);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (sens_enable[1]) n++;
        end
        total++;
        if (!got || n != T + 1) begin
            bad++;
            $display("FAIL timeout_enable_len: %0d cycles (rsp seen %b), required %0d", n, got, T + 1);
        end
        total++;
        if ({rsp_command, rsp_value, rsp_address} !== {8'h1F, 8'h1F, 8'd1}) begin
            bad++;
            $display("FAIL timeout_rsp: %h/%h addr %0d, required 1f/1f addr 1", rsp_command, rsp_value, rsp_address);
        end
        @(posedge clock);
        #1;
        base = iss_slot.size();
        repeat (P + 100) @(negedge clock);
        total++;
        if (iss_slot.size() != base) begin
            bad++;
            $display("FAIL timeout_no_loop: %0d loop issues, required 0", iss_slot.size() - base);
        end
    endtask

    task automatic test_loop();
        int a, b, base;
        logic [7:0] ka, kb, rc, rv, ra;
        int es[$];
        logic [7:0] ec[$];
        do_reset();
        a = int'($urandom_range(0, N - 2));
        b = int'($urandom_range(a + 1, N - 1));
        ka = 8'($urandom_range(3, 4));
        kb = 8'($urandom_range(3, 4));
        stub_delay[a] = int'($urandom_range(2, 8));
        stub_delay[b] = int'($urandom_range(2, 8));
        stub_cmd[a] = 8'($urandom);
        stub_val[a] = 8'($urandom);
        host_req(ka, 8'(a));
        wait_rsp(rc, rv, ra);
        total++;
        if ({rc, rv, ra} !== {stub_cmd[a], stub_val[a], 8'(a)}) begin
            bad++;
            $display("FAIL loop_start_rsp: %h/%h addr %0d, required %h/%h addr %0d", rc, rv, ra, stub_cmd[a], stub_val[a], a);
        end
        host_req(kb, 8'(b));
        wait_rsp(rc, rv, ra);
        m_active[a] = 1'b1;
        m_hum[a] = ka == 8'h04;
        m_active[b] = 1'b1;
        m_hum[b] = kb == 8'h04;
        base = iss_slot.size();
        wait_issues(base, 4, 2500);
        model_rounds(2, es, ec);
        check_issues("loop_two", base, es, ec);
        host_req(8'($urandom_range(5, 6)), 8'(a));
        wait_rsp(rc, rv, ra);
        m_active[a] = 1'b0;
        base = iss_slot.size();
        wait_issues(base, 2, 2500);
        model_rounds(2, es, ec);
        check_issues("loop_one", base, es, ec);
    endtask

    task automatic test_priority();
        int base, held;
        bit stable = 1'b1;
        bit ok = 1'b0;
        logic [7:0] c, v, a;
        int es[$];
        logic [7:0] ec[$];
        do_reset();
        stub_delay[2] = 4;
        host_req(8'h03, 8'd2);
        wait_rsp(c, v, a);
        base = iss_slot.size();
        stub_delay[1] = int'($urandom_range(2, 10));
        stub_cmd[1] = 8'($urandom);
        stub_val[1] = 8'($urandom);
        rsp_ready = 1'b0;
        host_req(8'h01, 8'd1);
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (rsp_valid) break;
        end
        c = rsp_command;
        v = rsp_value;
        a = rsp_address;
        total++;
        if (rsp_valid !== 1'b1 || {c, v, a} !== {stub_cmd[1], stub_val[1], 8'd1}) begin
            bad++;
            $display("FAIL prio_rsp: rv=%b %h/%h addr %0d, required rv=1 %h/%h addr 1", rsp_valid, c, v, a, stub_cmd[1], stub_val[1]);
        end
        held = 0;
        while (cyc < P + 100 && held < 5000) begin
            @(negedge clock);
            held++;
            if (rsp_valid !== 1'b1 || {rsp_command, rsp_value, rsp_address} !== {c, v, a}) stable = 1'b0;
        end
        total++;
        if (!stable || held < 20) begin
            bad++;
            $display("FAIL prio_hold: stable=%b over %0d cycles, required stable=1 over >=20", stable, held);
        end
        stub_delay[0] = int'($urandom_range(2, 10));
        req_valid = 1'b1;
        req_command = 8'h02;
        req_address = 8'd0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL prio_accept: req_ready=0 required 1");
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        wait_issues(base, 3, 500);
        es = {1, 0, 2};
        ec = {8'h01, 8'h02, 8'h03};
        check_issues("prio_order", base, es, ec);
    endtask

    task automatic test_reset_mid();
        int base, rbase;
        logic [7:0] c, v, a;
        do_reset();
        stub_delay[0] = 3;
        host_req(8'h03, 8'd0);
        wait_rsp(c, v, a);
        stub_delay[1] = 0;
        host_req(8'h01, 8'd1);
        repeat (5) @(negedge clock);
        total++;
        if (sens_enable !== 4'b0010) begin
            bad++;
            $display("FAIL mid_pre_enable: %b, required 0010", sens_enable);
        end
        reset_n = 1'b0;
        @(negedge clock);
        total++;
        if ({sens_enable, rsp_valid, busy, req_ready} !== '0) begin
            bad++;
            $display("FAIL mid_reset: en=%b rv=%b busy=%b rr=%b, required all 0", sens_enable, rsp_valid, busy, req_ready);
        end
        reset_n = 1'b1;
        base = iss_slot.size();
        rbase = rsp_cnt;
        repeat (P + 200) @(negedge clock);
        total++;
        if (iss_slot.size() != base || rsp_cnt != rbase) begin
            bad++;
            $display("FAIL mid_after: %0d issues %0d rsp cycles, required 0 and 0", iss_slot.size() - base, rsp_cnt - rbase);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            stub_delay[i] = 5;
            stub_cmd[i] = '0;
            stub_val[i] = '0;
        end
        m_rr = 0;
        test_reset();
        test_route();
        test_bad_addr();
        test_timeout();
        test_loop();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
